// File: rtl/sw_pkg.sv
// Shared switch packet definitions: field offsets/widths and the packet type.
// Packet width and port count come from the PKTW / PORT macros; defaults are provided here.
`ifndef PKTW
`define PKTW 16
`endif
`ifndef PORT
`define PORT 4
`endif

package sw_pkg;

    localparam int unsigned PKTW    = `PKTW;
    localparam int unsigned PW      = PKTW + 1;
    localparam int unsigned NPORT   = `PORT;

    localparam int unsigned V_BIT   = PKTW;
    localparam int unsigned DST_W   = 2;
    localparam int unsigned DST_LSB = PKTW - DST_W;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned SRC_LSB = DST_LSB - SRC_W;
    localparam int unsigned SEQ_W   = 4;
    localparam int unsigned SEQ_LSB = SRC_LSB - SEQ_W;

    typedef logic [PW-1:0] pkt_t;

    function automatic logic [DST_W-1:0] pkt_dst(input pkt_t p);
        return p[DST_LSB +: DST_W];
    endfunction

    function automatic logic [SRC_W-1:0] pkt_src(input pkt_t p);
        return p[SRC_LSB +: SRC_W];
    endfunction

    function automatic logic [SEQ_W-1:0] pkt_seq(input pkt_t p);
        return p[SEQ_LSB +: SEQ_W];
    endfunction

endpackage

// File: rtl/sw_rx_fifo.sv
// Synchronous receive FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable. Caller only pushes when not full or when popping in the same cycle.
module sw_rx_fifo #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    // Next-state for storage and pointers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_i) begin
            mem_d[wr_ptr_q[AW-1:0]] = din_i;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/sw_rx_port.sv
// Receive end of one switch output: input register, classifier, FIFO, saturating stats.
// Optional sequence checker enabled with macro SEQ_CHECK_EN.
module sw_rx_port
    import sw_pkg::*;
#(
    parameter int unsigned MY_PORT = 0,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [`PKTW:0]  pkt_i,
    input  logic            rd_rdy_i,
    output logic            rd_vld_o,
    output logic [`PKTW:0]  rd_pkt_o,
    output logic [CNTW-1:0] cnt_rx_o,
    output logic [CNTW-1:0] cnt_mis_o,
    output logic [CNTW-1:0] cnt_ovf_o,
`ifdef SEQ_CHECK_EN
    output logic [CNTW-1:0] cnt_seq_o,
`endif
    output logic            err_o
);

    pkt_t            in_q, in_d;
    logic [CNTW-1:0] cnt_rx_q, cnt_rx_d;
    logic [CNTW-1:0] cnt_mis_q, cnt_mis_d;
    logic [CNTW-1:0] cnt_ovf_q, cnt_ovf_d;
    logic            err_q, err_d;
    logic            full, empty;
    logic            hit, mis, ovf, push, pop, seq_err;

`ifdef SEQ_CHECK_EN
    logic [SEQ_W-1:0] exp_q [NPORT];
    logic [SEQ_W-1:0] exp_d [NPORT];
    logic [CNTW-1:0]  cnt_seq_q, cnt_seq_d;
`endif

    // Classify the registered packet and decide push / drop
    always_comb begin
        in_d = pkt_i;
        pop  = !empty && rd_rdy_i;
        hit  = in_q[V_BIT] && (pkt_dst(in_q) == DST_W'(MY_PORT));
        mis  = in_q[V_BIT] && (pkt_dst(in_q) != DST_W'(MY_PORT));
        push = hit && (!full || pop);
        ovf  = hit && full && !pop;
    end

`ifdef SEQ_CHECK_EN
    // Per-source expected sequence, resynced on every push
    always_comb begin
        exp_d   = exp_q;
        seq_err = 1'b0;
        if (push) begin
            seq_err = (pkt_seq(in_q) != exp_q[pkt_src(in_q)]);
            exp_d[pkt_src(in_q)] = pkt_seq(in_q) + SEQ_W'(1);
        end
        cnt_seq_d = (seq_err && cnt_seq_q != '1) ? cnt_seq_q + CNTW'(1) : cnt_seq_q;
    end
`else
    assign seq_err = 1'b0;
`endif

    // Saturating statistics and sticky error
    always_comb begin
        cnt_rx_d  = (push && cnt_rx_q  != '1) ? cnt_rx_q  + CNTW'(1) : cnt_rx_q;
        cnt_mis_d = (mis  && cnt_mis_q != '1) ? cnt_mis_q + CNTW'(1) : cnt_mis_q;
        cnt_ovf_d = (ovf  && cnt_ovf_q != '1) ? cnt_ovf_q + CNTW'(1) : cnt_ovf_q;
        err_d     = err_q || mis || ovf || seq_err;
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_q      <= '0;
            cnt_rx_q  <= '0;
            cnt_mis_q <= '0;
            cnt_ovf_q <= '0;
            err_q     <= 1'b0;
`ifdef SEQ_CHECK_EN
            cnt_seq_q <= '0;
            for (int i = 0; i < int'(NPORT); i++) begin
                exp_q[i] <= '0;
            end
`endif
        end else begin
            in_q      <= in_d;
            cnt_rx_q  <= cnt_rx_d;
            cnt_mis_q <= cnt_mis_d;
            cnt_ovf_q <= cnt_ovf_d;
            err_q     <= err_d;
`ifdef SEQ_CHECK_EN
            cnt_seq_q <= cnt_seq_d;
            exp_q     <= exp_d;
`endif
        end
    end

    sw_rx_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (in_q),
        .pop_i   (pop),
        .dout_o  (rd_pkt_o),
        .full_o  (full),
        .empty_o (empty)
    );

    assign rd_vld_o  = !empty;
    assign cnt_rx_o  = cnt_rx_q;
    assign cnt_mis_o = cnt_mis_q;
    assign cnt_ovf_o = cnt_ovf_q;
    assign err_o     = err_q;
`ifdef SEQ_CHECK_EN
    assign cnt_seq_o = cnt_seq_q;
`endif

endmodule

// File: tb/tb_sw_rx_port.sv
// Bench for sw_rx_port: directed scenarios plus random traffic against a queue-based model.
// Build with or without SEQ_CHECK_EN.
module tb_sw_rx_port;
    import sw_pkg::*;

    localparam int unsigned MYP = 2;
    localparam int unsigned DEP = 8;
    localparam int unsigned CW  = 8;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    pkt_t      pkt_i = '0;
    logic      rd_rdy_i = 1'b0;
    logic      rd_vld_o;
    pkt_t      rd_pkt_o;
    logic [CW-1:0] cnt_rx_o, cnt_mis_o, cnt_ovf_o;
    logic      err_o;

    pkt_t      pkt2 = '0;
    logic      rdy2 = 1'b0;
    logic      vld2, err2;
    pkt_t      rpkt2;
    logic [1:0] rx2, mis2, ovf2;

`ifdef SEQ_CHECK_EN
    logic [CW-1:0] cnt_seq_o;
    logic [1:0]    seq2;
`endif

    sw_rx_port #(.MY_PORT(MYP), .DEPTH(DEP), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .pkt_i(pkt_i), .rd_rdy_i(rd_rdy_i),
        .rd_vld_o(rd_vld_o), .rd_pkt_o(rd_pkt_o),
        .cnt_rx_o(cnt_rx_o), .cnt_mis_o(cnt_mis_o), .cnt_ovf_o(cnt_ovf_o),
`ifdef SEQ_CHECK_EN
        .cnt_seq_o(cnt_seq_o),
`endif
        .err_o(err_o)
    );

    sw_rx_port #(.MY_PORT(0), .DEPTH(4), .CNTW(2)) dut_sat (
        .clk(clk), .rst(rst), .pkt_i(pkt2), .rd_rdy_i(rdy2),
        .rd_vld_o(vld2), .rd_pkt_o(rpkt2),
        .cnt_rx_o(rx2), .cnt_mis_o(mis2), .cnt_ovf_o(ovf2),
`ifdef SEQ_CHECK_EN
        .cnt_seq_o(seq2),
`endif
        .err_o(err2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    pkt_t     mq[$];
    pkt_t     m_stage;
    int       m_rx, m_mis, m_ovf, m_seq;
    bit       m_err;
    bit [3:0] m_exp [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v, input int w);
        return (v >= (1 << w) - 1) ? v : v + 1;
    endfunction

    function automatic pkt_t mkpkt(input bit v, input int dst, input int src, input int seq, input int pay);
        pkt_t p;
        p = pkt_t'(pay);
        p[V_BIT] = v;
        p[DST_LSB +: 2] = 2'(dst);
        p[SRC_LSB +: 2] = 2'(src);
        p[SEQ_LSB +: 4] = 4'(seq);
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_stage = '0;
        m_rx = 0; m_mis = 0; m_ovf = 0; m_seq = 0;
        m_err = 0;
        for (int i = 0; i < 4; i++) m_exp[i] = 4'd0;
    endtask

    // One clock edge of the model: the staged packet is classified, the head may leave
    task automatic model_edge(input pkt_t p, input bit rdy);
        bit pop;
        int src;
        pop = (mq.size() != 0) && rdy;
        if (m_stage[V_BIT]) begin
            if (int'(m_stage[DST_LSB +: 2]) == int'(MYP)) begin
                if (mq.size() < int'(DEP) || pop) begin
                    mq.push_back(m_stage);
                    m_rx = sat_inc(m_rx, CW);
`ifdef SEQ_CHECK_EN
                    src = int'(m_stage[SRC_LSB +: 2]);
                    if (m_stage[SEQ_LSB +: 4] != m_exp[src]) begin
                        m_seq = sat_inc(m_seq, CW);
                        m_err = 1;
                    end
                    m_exp[src] = m_stage[SEQ_LSB +: 4] + 4'd1;
`else
                    src = 0;
`endif
                end else begin
                    m_ovf = sat_inc(m_ovf, CW);
                    m_err = 1;
                end
            end else begin
                m_mis = sat_inc(m_mis, CW);
                m_err = 1;
            end
        end
        if (pop) void'(mq.pop_front());
        m_stage = p;
    endtask

    task automatic check_outputs();
        chk("rd_vld", 32'(rd_vld_o), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("rd_pkt", 32'(rd_pkt_o), 32'(mq[0]));
        chk("cnt_rx", 32'(cnt_rx_o), 32'(m_rx));
        chk("cnt_mis", 32'(cnt_mis_o), 32'(m_mis));
        chk("cnt_ovf", 32'(cnt_ovf_o), 32'(m_ovf));
        chk("err", 32'(err_o), 32'(m_err));
`ifdef SEQ_CHECK_EN
        chk("cnt_seq", 32'(cnt_seq_o), 32'(m_seq));
`endif
    endtask

    task automatic step(input pkt_t p, input bit rdy);
        @(negedge clk);
        check_outputs();
        pkt_i = p;
        rd_rdy_i = rdy;
        model_edge(p, rdy);
    endtask

    // Asynchronous reset asserted between edges, checked before any clock arrives
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        pkt_i = '0;
        rd_rdy_i = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_pkt", 32'(rd_pkt_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs();
        chk("rst_pkt", 32'(rd_pkt_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-traffic with three packets buffered
        for (int i = 0; i < 3; i++) step(mkpkt(1, MYP, 0, i, 16 + i), 0);
        step('0, 0);
        step('0, 0);
        chk("t1_fill", 32'(cnt_rx_o), 32'd3);
        do_reset();
        step('0, 0);

        // Single packet latency with immediate pop
        step(mkpkt(1, MYP, 0, 0, 8'hA5), 1);
        step('0, 1);
        step('0, 1);
        chk("t2_vld", 32'(rd_vld_o), 32'd1);
        chk("t2_pkt", 32'(rd_pkt_o), 32'(mkpkt(1, MYP, 0, 0, 8'hA5)));
        step('0, 1);
        chk("t2_rx", 32'(cnt_rx_o), 32'd1);

        // Misrouted and invalid packets
        do_reset();
        step(mkpkt(1, 1, 0, 0, 8'h11), 1);
        step(mkpkt(0, MYP, 0, 0, 8'h22), 1);
        step(mkpkt(0, 1, 0, 0, 8'h33), 1);
        step('0, 1);
        chk("t3_mis", 32'(cnt_mis_o), 32'd1);
        chk("t3_err", 32'(err_o), 32'd1);
        chk("t3_vld", 32'(rd_vld_o), 32'd0);

        // Overflow then same-cycle pop+push while full
        do_reset();
        for (int i = 0; i < int'(DEP) + 2; i++) step(mkpkt(1, MYP, 0, i, 8'h40 + i), 0);
        step(mkpkt(1, MYP, 0, 10, 8'h7E), 0);
        step('0, 0);
        chk("t4_ovf", 32'(cnt_ovf_o), 32'd2);
        step(mkpkt(1, MYP, 0, 11, 8'h7F), 0);
        step('0, 1);
        chk("t4_ovf_hold", 32'(cnt_ovf_o), 32'd3);
        for (int i = 0; i < int'(DEP) + 2; i++) step('0, 1);
        chk("t4_empty", 32'(rd_vld_o), 32'd0);

`ifdef SEQ_CHECK_EN
        // Sequence gap on one source
        do_reset();
        step(mkpkt(1, MYP, 1, 0, 1), 1);
        step(mkpkt(1, MYP, 1, 1, 2), 1);
        step(mkpkt(1, MYP, 1, 3, 3), 1);
        step(mkpkt(1, MYP, 1, 4, 4), 1);
        step('0, 1);
        step('0, 1);
        chk("t5_seq", 32'(cnt_seq_o), 32'd1);
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int dst;
            dst = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) dst = int'(MYP);
            step(mkpkt(bit'($urandom_range(0, 3) != 0), dst, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 255))),
                 bit'($urandom_range(0, 2) == 0));
            if (i == 300) do_reset();
        end
        for (int i = 0; i < int'(DEP) + 3; i++) step('0, 1);

        // Counter saturation on a 2-bit instance
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pkt2 = mkpkt(1, 1, 0, 0, i);
        end
        @(negedge clk);
        pkt2 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_mis_sat", 32'(mis2), 32'd3);
        chk("t6_err", 32'(err2), 32'd1);
        chk("t6_vld", 32'(vld2), 32'd0);
        chk("t6_rx", 32'(rx2), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
